hqc_rmencod_top: RTL and testbench

HQC_RMENCOD_TOP -- requirements
Module: hqc_rmencod_top

---
 rtl/hqc_encod_pkg.sv | 26 ++
 rtl/hqc_rm_cw.sv | 21 ++
 rtl/hqc_rmencod_top.sv | 111 +++++++++++
 tb/tb_hqc_rmencod_top.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hqc_encod_pkg.sv
// Shared HQC encoder constants: per-security-level sizes and the encoder FSM state type.
package hqc_encod_pkg;

  localparam int unsigned MSG_W = 8;
  localparam int unsigned CW_W  = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } rm_state_t;

  function automatic int unsigned n1_of(input int unsigned sec);
    return (sec == 128) ? 46 : (sec == 192) ? 56 : 90;
  endfunction

  function automatic int unsigned mult_of(input int unsigned sec);
    return (sec == 128) ? 3 : 5;
  endfunction

  function automatic int unsigned out_aw_of(input int unsigned sec);
    return (sec == 128) ? 8 : 9;
  endfunction

endpackage

// File: rtl/hqc_rm_cw.sv
// Combinational RM(1,7) mapping: one message byte to a 128-bit codeword.
module hqc_rm_cw
  import hqc_encod_pkg::*;
(
  input  logic [MSG_W-1:0] msg,
  output logic [CW_W-1:0]  cw_c
);

  logic [6:0] idx;

  // Bit j is m0 plus the inner product of m[7:1] with the 7-bit index j.
  always_comb begin
    cw_c = '0;
    idx  = '0;
    for (int j = 0; j < 128; j++) begin
      idx     = 7'(j);
      cw_c[j] = msg[0] ^ (^(msg[7:1] & idx));
    end
  end

endmodule

// File: rtl/hqc_rmencod_top.sv
// HQC Reed-Muller encoder: each RS byte becomes MULTIPLICITY identical RM(1,7) words written to RAM.
module hqc_rmencod_top
  import hqc_encod_pkg::*;
#(
  parameter int unsigned PARAM_SECURITY = 128,
  parameter int unsigned MULTIPLICITY   = mult_of(PARAM_SECURITY),
  parameter int unsigned PARAM_N1       = n1_of(PARAM_SECURITY),
  parameter int unsigned OUT_AW         = out_aw_of(PARAM_SECURITY),
  parameter int unsigned DOUT_W         = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  input  logic [7:0]        din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  output logic [DOUT_W-1:0] ram_dout_o,
  output logic              ram_dout_wr_o,
  output logic [OUT_AW-1:0] ram_dout_addr_o,
  output logic              done_o
);

  localparam int unsigned BYTE_W = $clog2(PARAM_N1 + 1);
  localparam int unsigned REP_W  = $clog2(MULTIPLICITY + 1);

  rm_state_t           state_q, state_d;
  logic [BYTE_W-1:0]   byte_q;
  logic [REP_W-1:0]    rep_q;
  logic [OUT_AW-1:0]   addr_q;
  logic [DOUT_W-1:0]   cw_q;
  logic                busy_q, ready_q, wr_q, done_q;
  logic [CW_W-1:0]     cw_c;
  logic                start_c, accept_c, last_rep_c;

  hqc_rm_cw u_rm_cw (
    .msg  (din_i),
    .cw_c (cw_c)
  );

  // Next-state and control strobes.
  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    accept_c   = 1'b0;
    last_rep_c = (rep_q == REP_W'(MULTIPLICITY - 1));
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_c = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (din_valid_i && ready_q) begin
          accept_c = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last_rep_c) begin
          state_d = (byte_q == BYTE_W'(PARAM_N1)) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs (outputs track the next state).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      rep_q   <= '0;
      addr_q  <= '0;
      cw_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      ready_q <= (state_d == ST_LOAD);
      wr_q    <= (state_d == ST_WRITE);
      done_q  <= (state_d == ST_DONE);
      if (start_c) begin
        byte_q <= '0;
        rep_q  <= '0;
        addr_q <= '0;
      end
      if (accept_c) begin
        cw_q   <= DOUT_W'(cw_c);
        byte_q <= byte_q + BYTE_W'(1);
      end
      if (wr_q) begin
        addr_q <= addr_q + OUT_AW'(1);
        rep_q  <= last_rep_c ? '0 : rep_q + REP_W'(1);
      end
    end
  end

  assign busy_o          = busy_q;
  assign din_ready_o     = ready_q;
  assign ram_dout_o      = cw_q;
  assign ram_dout_wr_o   = wr_q;
  assign ram_dout_addr_o = addr_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_hqc_rmencod_top.sv
// Bench for hqc_rmencod_top: 128- and 256-level instances checked against a write scoreboard.
module tb_hqc_rmencod_top;

  localparam int N1_A = 46;
  localparam int M_A  = 3;
  localparam int N1_B = 90;
  localparam int M_B  = 5;

  typedef struct packed {
    logic [8:0]   addr;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]   din;
    logic [127:0] cw;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start [2];
  logic [7:0]   din   [2];
  logic         valid [2];

  logic         busy0, rdy0, wr0, done0;
  logic [127:0] dout0;
  logic [7:0]   addr0;
  logic         busy1, rdy1, wr1, done1;
  logic [127:0] dout1;
  logic [8:0]   addr1;

  hqc_rmencod_top #(.PARAM_SECURITY(128)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .busy_o(busy0),
    .din_i(din[0]), .din_valid_i(valid[0]), .din_ready_o(rdy0),
    .ram_dout_o(dout0), .ram_dout_wr_o(wr0), .ram_dout_addr_o(addr0), .done_o(done0)
  );

  hqc_rmencod_top #(.PARAM_SECURITY(256)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .busy_o(busy1),
    .din_i(din[1]), .din_valid_i(valid[1]), .din_ready_o(rdy1),
    .ram_dout_o(dout1), .ram_dout_wr_o(wr1), .ram_dout_addr_o(addr1), .done_o(done1)
  );

  int nvec = 0;
  int nerr = 0;
  exp_t q0[$];
  exp_t q1[$];
  int exp_addr [2];
  int wr_cnt   [2];
  int done_cnt [2];
  logic prev_wr   [2];
  logic [8:0] prev_addr [2];
  logic prev_done [2];
  logic [7:0]   mbyte [90];
  logic [127:0] mcw   [90];
  vec_t tbl [9];

  function automatic logic [127:0] rm_model(input logic [7:0] m);
    logic [127:0] r;
    logic [6:0] j;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      j = 7'(i);
      r[i] = m[0] ^ (^(m[7:1] & j));
    end
    return r;
  endfunction

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  // Scoreboard pop/compare for every RAM write, plus done-pulse placement.
  task automatic mon(input int d, input logic wr, input logic [8:0] addr,
                     input logic [127:0] data, input logic rdy, input logic dn);
    exp_t e;
    int total;
    bit empty;
    total = (d == 0) ? N1_A * M_A : N1_B * M_B;
    if (wr) begin
      nvec++;
      wr_cnt[d]++;
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        nerr++;
        $display("FAIL wr_unexpected dut%0d got addr=%0d data=%h required no write", d, addr, data);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (addr !== e.addr || data !== e.data) begin
          nerr++;
          $display("FAIL wr_word dut%0d got addr=%0d data=%h required addr=%0d data=%h",
                   d, addr, data, e.addr, e.data);
        end
      end
      if (rdy) begin
        nerr++;
        $display("FAIL ready_in_write dut%0d got ready=1 required 0", d);
      end
    end
    if (dn) begin
      nvec++;
      done_cnt[d]++;
      if (!prev_wr[d] || prev_addr[d] != 9'(total - 1) || prev_done[d]) begin
        nerr++;
        $display("FAIL done_place dut%0d got prev_wr=%0d prev_addr=%0d prev_done=%0d required 1/%0d/0",
                 d, prev_wr[d], prev_addr[d], prev_done[d], total - 1);
      end
    end
    prev_wr[d]   = wr;
    prev_addr[d] = addr;
    prev_done[d] = dn;
  endtask

  always @(negedge clk) begin
    mon(0, wr0, 9'(addr0), dout0, rdy0, done0);
    mon(1, wr1, addr1, dout1, rdy1, done1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    nvec++;
    if (got !== req) begin
      nerr++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic check_zero0();
    chk("rst_busy",  128'(busy0), '0);
    chk("rst_ready", 128'(rdy0),  '0);
    chk("rst_wr",    128'(wr0),   '0);
    chk("rst_done",  128'(done0), '0);
    chk("rst_dout",  dout0,       '0);
    chk("rst_addr",  128'(addr0), '0);
  endtask

  // All driver tasks enter and leave 1 time unit after a rising edge.
  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input logic [127:0] e, input int gap);
    int m;
    bit ok;
    exp_t x;
    m = (d == 0) ? M_A : M_B;
    valid[d] = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    din[d]   = b;
    valid[d] = 1'b1;
    for (int r = 0; r < m; r++) begin
      x.addr = 9'(exp_addr[d] + r);
      x.data = e;
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    exp_addr[d] += m;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rdy_of(d)) begin ok = 1'b1; break; end
    end
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL accept_timeout dut%0d got no ready required ready within 200 cycles", d);
    end
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  task automatic run_msg(input int d, input int gapmax, input int start_at, input int rst_at);
    int n1, m, dbefore;
    bit seen;
    n1 = (d == 0) ? N1_A : N1_B;
    m  = (d == 0) ? M_A : M_B;
    exp_addr[d] = 0;
    wr_cnt[d]   = 0;
    dbefore     = done_cnt[d];
    pulse_start(d);
    for (int i = 0; i < n1; i++) begin
      send_byte(d, mbyte[i], mcw[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      if (i == start_at) pulse_start(d);
      if (i == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check_zero0();
        q0.delete();
        @(posedge clk); #1;
        return;
      end
    end
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (done_cnt[d] > dbefore) begin seen = 1'b1; break; end
    end
    chk("done_seen",  128'(seen), 128'(1));
    chk("write_count", 128'(wr_cnt[d]), 128'(n1 * m));
    chk("queue_empty", 128'((d == 0) ? q0.size() : q1.size()), '0);
    @(negedge clk); #1;
    chk("done_single", 128'(done_cnt[d] - dbefore), 128'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{8'h00, 128'h0};
    tbl[1] = '{8'h01, {128{1'b1}}};
    tbl[2] = '{8'h02, {32{4'hA}}};
    tbl[3] = '{8'h80, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}};
    tbl[4] = '{8'h03, {32{4'h5}}};
    tbl[5] = '{8'h04, {32{4'hC}}};
    tbl[6] = '{8'h08, {16{8'hF0}}};
    tbl[7] = '{8'h10, {8{16'hFF00}}};
    tbl[8] = '{8'h81, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}};

    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; din[d] = '0; valid[d] = 1'b0;
      exp_addr[d] = 0; wr_cnt[d] = 0; done_cnt[d] = 0;
      prev_wr[d] = 1'b0; prev_addr[d] = '0; prev_done[d] = 1'b0;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_zero0();
    @(posedge clk); #1;

    // Known-answer bytes first, then random fill; start in the first cycle out of reset.
    for (int i = 0; i < 90; i++) begin
      if (i < 9) begin
        mbyte[i] = tbl[i].din;
        mcw[i]   = tbl[i].cw;
      end else begin
        mbyte[i] = 8'($urandom);
        mcw[i]   = rm_model(mbyte[i]);
      end
    end
    rst_n = 1'b1;
    run_msg(0, 0, -1, -1);
    run_msg(0, 3, -1, -1);

    // Start ignored during byte 10's burst, reset during byte 20's burst.
    run_msg(0, 0, 10, 20);
    rst_n = 1'b1;
    run_msg(0, 0, -1, -1);

    for (int i = 0; i < 90; i++) begin
      mbyte[i] = 8'($urandom);
      mcw[i]   = rm_model(mbyte[i]);
    end
    run_msg(1, 2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
